// File: rtl/gpr_wb_arbiter.sv
// gpr_wb_arbiter: single GPR write-port arbiter.
// Port A (pipeline writeback) writes with zero latency. Port B (multiply/divide
// results) is buffered in a DEPTH-entry FIFO and drains when A leaves the port idle.
// A write from A to register r kills any queued B entry that targets r.
// Optional starvation guard: define GPR_WB_STARVE_GUARD_EN.
//
// Port B handshake: a result transfers on a rising edge where b_valid && b_ready
// are both high. b_ready depends only on FIFO occupancy (and is 1 during reset);
// it never depends on b_valid.
module gpr_wb_arbiter #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        a_valid,
    input  logic [4:0]  a_reg,
    input  logic [31:0] a_data,
    input  logic [31:0] a_pc,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [4:0]  b_reg,
    input  logic [31:0] b_data,
    input  logic [31:0] b_pc,
    output logic        regwrite,
    output logic [4:0]  write_reg,
    output logic [31:0] write_data,
    output logic [31:0] pc_new,
    output logic        stall_pipe,
    output logic [31:0] pending_mask
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [4:0]       reg_q  [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [31:0]      pc_q   [DEPTH];
    logic [DEPTH-1:0] live_q, live_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    logic full, empty, push, pop, a_grant, a_kill, stall;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign a_grant = !reset && a_valid && !stall;
    assign a_kill  = a_grant && (a_reg != 5'd0);
    // The head drains in any non-reset cycle where A does not own the port.
    assign pop     = !reset && !empty && !a_grant;
    assign push    = !reset && b_valid && !full;
    assign b_ready = reset || !full;

`ifdef GPR_WB_STARVE_GUARD_EN
    logic [1:0] starve_q, starve_d;

    // After three A grants against a full FIFO, the fourth A request is held off.
    assign stall = !reset && a_valid && !empty && (starve_q == 2'd3);

    // Saturating starvation counter: cleared by any pop, bumped while full and A wins.
    always_comb begin
        starve_d = starve_q;
        if (pop) begin
            starve_d = 2'd0;
        end else if (full && a_grant && (starve_q != 2'd3)) begin
            starve_d = starve_q + 2'd1;
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_q <= 2'd0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    assign stall = 1'b0;
`endif

    assign stall_pipe = stall;

    // Write-port mux: A fields when A wins, head fields on a pop, otherwise idle zeros.
    always_comb begin
        regwrite   = 1'b0;
        write_reg  = 5'd0;
        write_data = 32'd0;
        pc_new     = 32'd0;
        if (a_grant) begin
            regwrite   = (a_reg != 5'd0);
            write_reg  = a_reg;
            write_data = a_data;
            pc_new     = a_pc;
        end else if (pop) begin
            regwrite   = live_q[rd_ptr_q];
            write_reg  = reg_q[rd_ptr_q];
            write_data = data_q[rd_ptr_q];
            pc_new     = pc_q[rd_ptr_q];
        end
    end

    // Next-state for pointers, occupancy and per-slot live bits (pop, then kill, then push).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        live_d   = live_q;
        if (pop) begin
            rd_ptr_d         = rd_ptr_q + PW'(1);
            live_d[rd_ptr_q] = 1'b0;
        end
        if (a_kill) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (reg_q[i] == a_reg) begin
                    live_d[i] = 1'b0;
                end
            end
        end
        if (push) begin
            wr_ptr_d         = wr_ptr_q + PW'(1);
            // An entry arriving in the same cycle A writes its register is born dead.
            live_d[wr_ptr_q] = (b_reg != 5'd0) && !(a_kill && (b_reg == a_reg));
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    // FIFO control state; reset flushes every queued entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            live_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            live_q   <= live_d;
        end
    end

    // FIFO payload storage; contents are qualified by live_q and the count, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            reg_q[wr_ptr_q]  <= b_reg;
            data_q[wr_ptr_q] <= b_data;
            pc_q[wr_ptr_q]   <= b_pc;
        end
    end

    // Hazard mask: one bit per register targeted by a live queued entry.
    always_comb begin
        pending_mask = 32'd0;
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (live_q[i]) begin
                    pending_mask[reg_q[i]] = 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// tb_gpr_wb_arbiter: directed scenarios plus randomized traffic for gpr_wb_arbiter,
// checked cycle by cycle against a queue-based reference model.
// Honours GPR_WB_STARVE_GUARD_EN in the same way as the design.
module tb_gpr_wb_arbiter;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        a_valid;
    logic [4:0]  a_reg;
    logic [31:0] a_data;
    logic [31:0] a_pc;
    logic        b_valid;
    logic        b_ready;
    logic [4:0]  b_reg;
    logic [31:0] b_data;
    logic [31:0] b_pc;
    logic        regwrite;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic [31:0] pc_new;
    logic        stall_pipe;
    logic [31:0] pending_mask;

    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
        logic [31:0] pc;
        bit          live;
    } ent_t;

    ent_t        mq[$];
    int          starve;
    bit          guard;
    bit          last_stall;
    int          total;
    int          bad;
    logic [31:0] exp_rf [32];
    logic [31:0] obs_rf [32];

    gpr_wb_arbiter #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .a_valid      (a_valid),
        .a_reg        (a_reg),
        .a_data       (a_data),
        .a_pc         (a_pc),
        .b_valid      (b_valid),
        .b_ready      (b_ready),
        .b_reg        (b_reg),
        .b_data       (b_data),
        .b_pc         (b_pc),
        .regwrite     (regwrite),
        .write_reg    (write_reg),
        .write_data   (write_data),
        .pc_new       (pc_new),
        .stall_pipe   (stall_pipe),
        .pending_mask (pending_mask)
    );

    // Clock.
    always #5 clk = ~clk;

    // Register file as actually written by the DUT.
    always @(posedge clk) begin
        if (regwrite) obs_rf[write_reg] <= write_data;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Check outputs for the current inputs, then advance the model across the next edge.
    task automatic tick();
        logic        e_rw;
        logic [4:0]  e_wr;
        logic [31:0] e_wd;
        logic [31:0] e_pc;
        logic [31:0] e_mask;
        logic        e_stall;
        logic        e_bready;
        bit          a_win;
        bit          popping;
        bit          kill;
        ent_t        n;
        #1;
        e_stall = 1'b0;
        if (reset) begin
            check("rst_regwrite", {31'd0, regwrite}, 32'd0);
            check("rst_write_reg", {27'd0, write_reg}, 32'd0);
            check("rst_write_data", write_data, 32'd0);
            check("rst_pc_new", pc_new, 32'd0);
            check("rst_b_ready", {31'd0, b_ready}, 32'd1);
            check("rst_stall", {31'd0, stall_pipe}, 32'd0);
            check("rst_pending", pending_mask, 32'd0);
            mq.delete();
            starve = 0;
        end else begin
            e_bready = (mq.size() < DEPTH);
            e_stall  = guard && (starve == 3) && a_valid && (mq.size() > 0);
            e_mask   = 32'd0;
            foreach (mq[i]) if (mq[i].live) e_mask[mq[i].r] = 1'b1;
            a_win    = a_valid && !e_stall;
            popping  = !a_win && (mq.size() > 0);
            e_rw = 1'b0; e_wr = 5'd0; e_wd = 32'd0; e_pc = 32'd0;
            if (a_win) begin
                e_rw = (a_reg != 5'd0); e_wr = a_reg; e_wd = a_data; e_pc = a_pc;
            end else if (popping) begin
                e_rw = mq[0].live; e_wr = mq[0].r; e_wd = mq[0].d; e_pc = mq[0].pc;
            end
            check("regwrite", {31'd0, regwrite}, {31'd0, e_rw});
            if (e_rw) begin
                check("write_reg", {27'd0, write_reg}, {27'd0, e_wr});
                check("write_data", write_data, e_wd);
                check("pc_new", pc_new, e_pc);
            end
            check("b_ready", {31'd0, b_ready}, {31'd0, e_bready});
            check("stall_pipe", {31'd0, stall_pipe}, {31'd0, e_stall});
            check("pending_mask", pending_mask, e_mask);

            if (e_rw) exp_rf[e_wr] = e_wd;
            if (popping) void'(mq.pop_front());
            kill = a_win && (a_reg != 5'd0);
            if (kill) foreach (mq[i]) if (mq[i].r == a_reg) mq[i].live = 1'b0;
            if (b_valid && e_bready) begin
                n.r = b_reg; n.d = b_data; n.pc = b_pc;
                n.live = (b_reg != 5'd0) && !(kill && (b_reg == a_reg));
                mq.push_back(n);
            end
            if (popping) starve = 0;
            else if (!e_bready && a_win && starve < 3) starve++;
        end
        last_stall = e_stall;
        @(negedge clk);
    endtask

    task automatic cyc(input bit av, input logic [4:0] ar, input logic [31:0] ad,
                       input logic [31:0] apc, input bit bv, input logic [4:0] br,
                       input logic [31:0] bd, input logic [31:0] bpc);
        a_valid = av; a_reg = ar; a_data = ad; a_pc = apc;
        b_valid = bv; b_reg = br; b_data = bd; b_pc = bpc;
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 5'd0, 32'd0, 32'd0, 0, 5'd0, 32'd0, 32'd0);
    endtask

    initial begin
        total = 0; bad = 0; starve = 0; last_stall = 1'b0;
`ifdef GPR_WB_STARVE_GUARD_EN
        guard = 1'b1;
`else
        guard = 1'b0;
`endif
        for (int i = 0; i < 32; i++) begin
            exp_rf[i] = 32'd0;
            obs_rf[i] = 32'd0;
        end
        reset = 1'b1;
        a_valid = 0; a_reg = 0; a_data = 0; a_pc = 0;
        b_valid = 0; b_reg = 0; b_data = 0; b_pc = 0;
        @(negedge clk);

        // Reset for two cycles, then idle.
        idle(2);
        reset = 1'b0;
        idle(2);

        // A writes r5 while B enqueues r7; r7 drains next cycle.
        cyc(1, 5'd5, 32'h1234, 32'h100, 1, 5'd7, 32'hBEEF, 32'h200);
        idle(2);
        check("drain_r5", obs_rf[5], 32'h1234);
        check("drain_r7", obs_rf[7], 32'hBEEF);

        // WAW kill: queued r9 is overwritten by A, then drains silently.
        cyc(0, 5'd0, 32'd0, 32'd0, 1, 5'd9, 32'hAAAA, 32'h300);
        cyc(1, 5'd9, 32'h5555, 32'h304, 0, 5'd0, 32'd0, 32'd0);
        idle(2);
        check("waw_r9", obs_rf[9], 32'h5555);

        // Same-cycle kill of an entry being enqueued.
        cyc(1, 5'd11, 32'h7777, 32'h310, 1, 5'd11, 32'h8888, 32'h314);
        idle(2);
        check("same_cycle_kill_r11", obs_rf[11], 32'h7777);

        // Full back-pressure with A held high.
        cyc(1, 5'd1, 32'h11, 32'h400, 1, 5'd2, 32'h22, 32'h404);
        cyc(1, 5'd1, 32'h12, 32'h408, 1, 5'd3, 32'h33, 32'h40C);
        for (int i = 0; i < 3; i++) cyc(1, 5'd1, 32'h13 + i, 32'h410, 1, 5'd4, 32'h44, 32'h414);
        cyc(0, 5'd0, 32'd0, 32'd0, 1, 5'd4, 32'h44, 32'h414);
        idle(4);

        // Reg 0 entry occupies a slot but never writes.
        cyc(0, 5'd0, 32'd0, 32'd0, 1, 5'd0, 32'hFFFF, 32'h500);
        idle(2);
        check("reg0_stays0", obs_rf[0], 32'd0);

        // Starvation: FIFO kept full while A requests every cycle.
        for (int i = 0; i < 16; i++) begin
            if (last_stall) cyc(1, a_reg, a_data, a_pc, 1, 5'(12 + (i % 4)), 32'h600 + i, 32'h700 + i);
            else cyc(1, 5'(20 + (i % 3)), 32'h900 + i, 32'h800 + i, 1, 5'(12 + (i % 4)), 32'h600 + i, 32'h700 + i);
        end
        idle(4);

        // Mid-operation reset flushes the queue.
        cyc(0, 5'd0, 32'd0, 32'd0, 1, 5'd14, 32'hC0DE, 32'hA00);
        reset = 1'b1;
        cyc(1, 5'd15, 32'hDEAD, 32'hA04, 1, 5'd16, 32'hF00D, 32'hA08);
        reset = 1'b0;
        idle(2);
        check("flush_r14", obs_rf[14], exp_rf[14]);

        // Randomized traffic with a narrow register range to provoke kills.
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 199) == 0);
            if (last_stall && !reset) begin
                b_valid = ($urandom_range(0, 2) != 0);
                b_reg = 5'($urandom_range(0, 7)); b_data = $urandom; b_pc = $urandom;
                tick();
            end else begin
                cyc($urandom_range(0, 2) != 0, 5'($urandom_range(0, 7)), $urandom, $urandom,
                    $urandom_range(0, 2) != 0, 5'($urandom_range(0, 7)), $urandom, $urandom);
            end
        end
        reset = 1'b0;
        idle(DEPTH + 2);

        for (int i = 0; i < 32; i++) check($sformatf("rf_r%0d", i), obs_rf[i], exp_rf[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
